pipe_stage_reg: RTL and testbench

Parametrised pipeline-stage register that replaces the fixed per-stage control registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with a single reusable block. It carries a WIDTH-bit payload with a valid bit and a ready/valid handshake, supports a synchronous flush that turns the stage into a bubble, and optionally adds a one-entry skid buffer so `in_ready` is driven only from flops. Instantiated once per stage boundary in the pipeline datapath/control path.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_entry.sv | 22 ++
 rtl/pipe_stage_reg.sv | 97 +++++++++
 tb/tb_pipe_stage_reg.sv | 139 +++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the reusable pipeline-stage register.
package pipe_pkg;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_BUSY  = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  localparam int DEF_CTRL_WIDTH = 5;
endpackage

// File: rtl/pipe_entry.sv
// One payload register: load enable, control-field clear, async reset to zero.
module pipe_entry #(
  parameter int WIDTH      = 32,
  parameter int CTRL_WIDTH = 5
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ld,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // Mask of the low control bits; empty when CTRL_WIDTH is 0.
  localparam logic [WIDTH-1:0] CMASK =
    (CTRL_WIDTH == 0) ? '0 : ({WIDTH{1'b1}} >> (WIDTH - CTRL_WIDTH));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)   q <= '0;
    else if (clr) q <= q & ~CMASK;
    else if (ld)  q <= d;
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, flush-to-bubble and an
// optional skid entry so in_ready can come straight from the state flops.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CTRL_WIDTH = DEF_CTRL_WIDTH,
  parameter int SKID       = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             FLUSH,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);
  pipe_state_t      state, state_nxt;
  logic             in_fire, out_fire;
  logic             ld_main, ld_skid, sel_skid, drain;
  logic [WIDTH-1:0] main_d, skid_q;

  assign out_valid = (state != EMPTY);
  assign in_ready  = (SKID != 0) ? (state != FULL) : (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    ld_main   = 1'b0;
    ld_skid   = 1'b0;
    sel_skid  = 1'b0;
    drain     = 1'b0;
    if (FLUSH) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) begin
          ld_main   = 1'b1;
          state_nxt = BUSY;
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            ld_main = 1'b1;
          end else if (in_fire && SKID != 0) begin
            ld_skid   = 1'b1;
            state_nxt = FULL;
          end else if (out_fire) begin
            // Clear control bits on drain so an idle stage always shows a NOP.
            drain     = 1'b1;
            state_nxt = EMPTY;
          end
        end
        FULL: if (out_fire) begin
          ld_main   = 1'b1;
          sel_skid  = 1'b1;
          state_nxt = BUSY;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    case (state)
      BUSY:    occupancy = OCC_BUSY;
      FULL:    occupancy = OCC_FULL;
      default: occupancy = OCC_EMPTY;
    endcase
  end

  assign main_d = sel_skid ? skid_q : in_data;

  pipe_entry #(.WIDTH(WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) u_main (
    .CLK(CLK), .RST_N(RST_N), .ld(ld_main), .clr(FLUSH || drain),
    .d(main_d), .q(out_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_entry #(.WIDTH(WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) u_skid (
        .CLK(CLK), .RST_N(RST_N), .ld(ld_skid), .clr(FLUSH),
        .d(in_data), .q(skid_q)
      );
    end else begin : g_noskid
      assign skid_q = '0;
    end
  endgenerate
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a SKID=1 and a SKID=0 stage with identical stimulus and checks both
// against queue-based reference models.
module tb_pipe_stage_reg;
  localparam logic [31:0] CMASK = 32'h0000_001F;

  logic        CLK = 1'b0;
  logic        RST_N, FLUSH, in_valid, out_ready;
  logic [31:0] in_data;
  logic        r1_ir, r1_ov, r0_ir, r0_ov;
  logic [31:0] r1_od, r0_od;
  logic [1:0]  r1_occ, r0_occ;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] q1[$];
  logic [31:0] q0[$];

  always #5 CLK = ~CLK;

  pipe_stage_reg #(.WIDTH(32), .CTRL_WIDTH(5), .SKID(1)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .in_valid(in_valid), .in_ready(r1_ir),
    .in_data(in_data), .out_valid(r1_ov), .out_ready(out_ready), .out_data(r1_od),
    .occupancy(r1_occ)
  );

  pipe_stage_reg #(.WIDTH(32), .CTRL_WIDTH(5), .SKID(0)) u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .in_valid(in_valid), .in_ready(r0_ir),
    .in_data(in_data), .out_valid(r0_ov), .out_ready(out_ready), .out_data(r0_od),
    .occupancy(r0_occ)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Outputs implied by the current contents of each model queue.
  task automatic check_all();
    chk("s1_out_valid", 32'(r1_ov), 32'(q1.size() > 0));
    chk("s1_occupancy", 32'(r1_occ), 32'(q1.size()));
    chk("s1_in_ready", 32'(r1_ir), 32'(q1.size() < 2));
    if (q1.size() > 0) chk("s1_out_data", r1_od, q1[0]);
    else               chk("s1_bubble", r1_od & CMASK, 32'h0);
    chk("s0_out_valid", 32'(r0_ov), 32'(q0.size() > 0));
    chk("s0_occupancy", 32'(r0_occ), 32'(q0.size()));
    chk("s0_in_ready", 32'(r0_ir), 32'(q0.size() == 0 || out_ready));
    if (q0.size() > 0) chk("s0_out_data", r0_od, q0[0]);
    else               chk("s0_bubble", r0_od & CMASK, 32'h0);
  endtask

  // One clock: apply inputs, check, then advance the models across the edge.
  task automatic cyc(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    bit f1_in, f1_out, f0_in, f0_out;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    FLUSH     = fl;
    #1;
    check_all();
    f1_in  = iv && q1.size() < 2;
    f1_out = ordy && q1.size() > 0;
    f0_in  = iv && (q0.size() == 0 || ordy);
    f0_out = ordy && q0.size() > 0;
    @(posedge CLK);
    if (fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (f1_out) void'(q1.pop_front());
      if (f1_in)  q1.push_back(d);
      if (f0_out) void'(q0.pop_front());
      if (f0_in)  q0.push_back(d);
    end
    @(negedge CLK);
  endtask

  initial begin
    RST_N = 1'b0; FLUSH = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #1;
    chk("rst_s1_out_data", r1_od, 32'h0);
    chk("rst_s0_out_data", r0_od, 32'h0);
    check_all();
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // Streaming at full rate
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h11 + 32'(i), 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Skid fill then drain
    cyc(1'b1, 32'hA1, 1'b1, 1'b0);
    cyc(1'b1, 32'hA2, 1'b0, 1'b0);
    cyc(1'b1, 32'hA3, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush from FULL together with a new input
    cyc(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    chk("flush_s1_hold_upper", r1_od, 32'hFFFF_FFE0);
    chk("flush_s0_hold_upper", r0_od, 32'hFFFF_FFE0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Toggling back-pressure
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'h200 + 32'(i), 1'(i % 2), 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset with two entries held
    cyc(1'b1, 32'hB1, 1'b0, 1'b0);
    cyc(1'b1, 32'hB2, 1'b0, 1'b0);
    in_valid = 1'b0;
    RST_N = 1'b0;
    #1;
    q1.delete();
    q0.delete();
    chk("async_rst_s1_out_data", r1_od, 32'h0);
    chk("async_rst_s0_out_data", r0_od, 32'h0);
    check_all();
    #2 RST_N = 1'b1;
    @(negedge CLK);

    // Random stress
    for (int i = 0; i < 1000; i++)
      cyc(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 19) == 0));
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
